// File: rtl/def_pkg.sv
// Shared ALU definitions: opcode encodings, datapath widths, FSM states and the captured request.
package def_pkg;

    localparam int unsigned DATA_W          = 8;
    localparam int unsigned RES_W           = 16;
    localparam int unsigned OP_W            = 3;
    localparam int unsigned MUL_LAT_DEFAULT = 3;

    typedef enum logic [OP_W-1:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_MUL  = 2'b10
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        operation_t        op;
    } alu_req_t;

    // Unused encodings 101/110 fold onto no_op.
    function automatic operation_t decode_op(input logic [OP_W-1:0] raw);
        operation_t dec;
        case (raw)
            3'b001:  dec = add_op;
            3'b010:  dec = and_op;
            3'b011:  dec = xor_op;
            3'b100:  dec = mul_op;
            3'b111:  dec = rst_op;
            default: dec = no_op;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/alu_mul_pipe.sv
// 8x8 unsigned multiplier with LAT register stages and a valid bit that travels with the data.
module alu_mul_pipe
    import def_pkg::*;
#(
    parameter int unsigned LAT = MUL_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              valid_out,
    output logic [RES_W-1:0]  product
);

    logic [LAT-1:0]   vld_q;
    logic [RES_W-1:0] prod_q [LAT];

    // First stage multiplies; later stages only retime the product.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            vld_q <= {vld_q[LAT-2:0], valid_in};
            if (valid_in) begin
                prod_q[0] <= RES_W'(a) * RES_W'(b);
            end
            for (int i = 1; i < int'(LAT); i++) begin
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    assign valid_out = vld_q[LAT-1];
    assign product   = prod_q[LAT-1];

endmodule

// File: rtl/alu_core.sv
// Multi-cycle 8-bit ALU: edge-triggered start, single-cycle logic ops, pipelined multiply,
// one shared registered result and a one-cycle done pulse.
module alu_core
    import def_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [OP_W-1:0]   op,
    input  logic              start,
    output logic              done,
    output logic [RES_W-1:0]  result
);

    localparam int unsigned CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

    state_t           state, state_nxt;
    alu_req_t         cap_q;
    logic             start_q;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             done_nxt;
    logic [RES_W-1:0] result_nxt;

    logic             accept_c;
    operation_t       op_dec_c;
    logic             mul_valid;
    logic [RES_W-1:0] mul_product;
    logic [DATA_W:0]  sum_c;

    assign op_dec_c = decode_op(op);
    assign accept_c = start && !start_q && (state == S_IDLE);
    assign sum_c    = {1'b0, cap_q.a} + {1'b0, cap_q.b};

    // Operands go straight from the ports into the pipe so its first stage loads on the accept edge.
    alu_mul_pipe #(
        .LAT (MUL_LAT)
    ) u_mul_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid_in  (accept_c && (op_dec_c == mul_op)),
        .a         (A),
        .b         (B),
        .valid_out (mul_valid),
        .product   (mul_product)
    );

    // Start-edge detector and operand capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_q <= 1'b0;
            cap_q   <= '{a: '0, b: '0, op: no_op};
        end else begin
            start_q <= start;
            if (accept_c) begin
                cap_q <= '{a: A, b: B, op: op_dec_c};
            end
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            done   <= done_nxt;
            result <= result_nxt;
        end
    end

    // Next-state, counter and result selection.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        done_nxt   = 1'b0;
        result_nxt = result;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (accept_c) begin
                    state_nxt = (op_dec_c == mul_op) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                state_nxt = S_IDLE;
                done_nxt  = 1'b1;
                case (cap_q.op)
                    add_op:  result_nxt = RES_W'(sum_c);
                    and_op:  result_nxt = RES_W'(cap_q.a & cap_q.b);
                    xor_op:  result_nxt = RES_W'(cap_q.a ^ cap_q.b);
                    rst_op:  result_nxt = '0;
                    default: result_nxt = result;
                endcase
            end
            S_MUL: begin
                if ((cnt == CNT_W'(MUL_LAT - 1)) && mul_valid) begin
                    state_nxt  = S_IDLE;
                    done_nxt   = 1'b1;
                    result_nxt = mul_product;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: latency, results, start-edge rules, busy/abort behaviour.
module tb_alu_core;

    logic        clk;
    logic        reset_n;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;

    int errors = 0;
    int checks = 0;

    alu_core dut (
        .clk     (clk),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .op      (op),
        .start   (start),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, hold start until done, then run a few idle cycles; report first-done latency,
    // the result seen with it and the total number of done pulses.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                         input bit scramble, output int lat, output logic [15:0] res,
                         output int pulses);
        A = a; B = b; op = o; start = 1'b1;
        step();
        lat = -1; res = 16'hxxxx; pulses = 0;
        if (scramble) begin
            A = 8'h00; B = 8'h00; op = 3'b001;
        end
        for (int i = 1; i <= 8; i++) begin
            step();
            if (done === 1'b1) begin
                if (pulses == 0) begin
                    lat = i;
                    res = result;
                end
                pulses++;
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; A = '0; B = '0; op = '0;
        step(); step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result got=%h exp=0000", result); end
        #3 reset_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        int lat, pulses; logic [15:0] res;
        do_op(8'hFF, 8'hFF, 3'b001, 1'b0, lat, res, pulses);
        checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got=%0d exp=1", lat); end
        checks++; if (res !== 16'h01FE) begin errors++; $display("FAIL add_result got=%h exp=01fe", res); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL add_pulses got=%0d exp=1", pulses); end
        checks++; if (result !== 16'h01FE) begin errors++; $display("FAIL add_hold got=%h exp=01fe", result); end
    endtask

    task automatic test_mul();
        int lat, pulses; logic [15:0] res;
        do_op(8'hFF, 8'hFF, 3'b100, 1'b1, lat, res, pulses);
        checks++; if (lat !== 3) begin errors++; $display("FAIL mul_latency got=%0d exp=3", lat); end
        checks++; if (res !== 16'hFE01) begin errors++; $display("FAIL mul_result got=%h exp=fe01", res); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL mul_pulses got=%0d exp=1", pulses); end
        do_op(8'h0D, 8'h0B, 3'b100, 1'b0, lat, res, pulses);
        checks++; if (res !== 16'h008F) begin errors++; $display("FAIL mul_small got=%h exp=008f", res); end
    endtask

    task automatic test_logic();
        int lat, pulses; logic [15:0] res;
        do_op(8'hF0, 8'h3C, 3'b010, 1'b0, lat, res, pulses);
        checks++; if (res !== 16'h0030) begin errors++; $display("FAIL and_result got=%h exp=0030", res); end
        do_op(8'hF0, 8'h3C, 3'b011, 1'b0, lat, res, pulses);
        checks++; if (res !== 16'h00CC) begin errors++; $display("FAIL xor_result got=%h exp=00cc", res); end
        do_op(8'h12, 8'h34, 3'b000, 1'b0, lat, res, pulses);
        checks++; if (lat !== 1) begin errors++; $display("FAIL noop_latency got=%0d exp=1", lat); end
        checks++; if (res !== 16'h00CC) begin errors++; $display("FAIL noop_result got=%h exp=00cc", res); end
    endtask

    task automatic test_rst_op();
        int lat, pulses; logic [15:0] res;
        do_op(8'h55, 8'h66, 3'b111, 1'b0, lat, res, pulses);
        checks++; if (lat !== 1) begin errors++; $display("FAIL rstop_latency got=%0d exp=1", lat); end
        checks++; if (res !== 16'h0000) begin errors++; $display("FAIL rstop_result got=%h exp=0000", res); end
        do_op(8'h10, 8'h20, 3'b001, 1'b0, lat, res, pulses);
        checks++; if (res !== 16'h0030) begin errors++; $display("FAIL add_small got=%h exp=0030", res); end
        do_op(8'h77, 8'h11, 3'b101, 1'b0, lat, res, pulses);
        checks++; if (lat !== 1 || res !== 16'h0030) begin
            errors++; $display("FAIL op101 got lat=%0d res=%h exp lat=1 res=0030", lat, res);
        end
        do_op(8'h77, 8'h11, 3'b110, 1'b0, lat, res, pulses);
        checks++; if (lat !== 1 || res !== 16'h0030) begin
            errors++; $display("FAIL op110 got lat=%0d res=%h exp lat=1 res=0030", lat, res);
        end
    endtask

    task automatic test_reset_abort();
        int pulses = 0;
        A = 8'h12; B = 8'h34; op = 3'b100; start = 1'b1;
        step();
        step();
        reset_n = 1'b0;
        #1;
        checks++; if (done !== 1'b0 || result !== 16'h0000) begin
            errors++; $display("FAIL abort_in_reset got done=%b res=%h exp done=0 res=0000", done, result);
        end
        step(); step();
        start = 1'b0;
        #3 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0 || result !== 16'h0000) begin
            errors++; $display("FAIL abort_after got pulses=%0d res=%h exp 0/0000", pulses, result);
        end
        // start already high at reset release counts as a rising edge
        reset_n = 1'b0; A = 8'h03; B = 8'h04; op = 3'b001; start = 1'b1;
        #3 reset_n = 1'b1;
        step();
        step();
        checks++; if (done !== 1'b1 || result !== 16'h0007) begin
            errors++; $display("FAIL start_at_release got done=%b res=%h exp 1/0007", done, result);
        end
        start = 1'b0;
        step(); step();
    endtask

    task automatic test_held_start();
        int pulses = 0;
        A = 8'h01; B = 8'h02; op = 3'b001; start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        start = 1'b0;
        checks++; if (pulses !== 1) begin errors++; $display("FAIL held_pulses got=%0d exp=1", pulses); end
        checks++; if (result !== 16'h0003) begin errors++; $display("FAIL held_result got=%h exp=0003", result); end
        step();
    endtask

    task automatic test_busy_ignore();
        int pulses = 0;
        int lat = -1;
        int prev_done = 0;
        int dbl = 0;
        A = 8'h02; B = 8'h03; op = 3'b100; start = 1'b1;
        step();
        start = 1'b0;
        step();
        A = 8'h05; B = 8'h05; op = 3'b001; start = 1'b1;
        for (int i = 2; i <= 10; i++) begin
            step();
            if (done === 1'b1) begin
                if (pulses == 0) lat = i;
                pulses++;
                if (prev_done == 1) dbl++;
            end
            prev_done = (done === 1'b1) ? 1 : 0;
        end
        start = 1'b0;
        checks++; if (pulses !== 1 || lat !== 3) begin
            errors++; $display("FAIL busy_ignore got pulses=%0d lat=%0d exp 1/3", pulses, lat);
        end
        checks++; if (result !== 16'h0006) begin errors++; $display("FAIL busy_result got=%h exp=0006", result); end
        checks++; if (dbl !== 0) begin errors++; $display("FAIL done_double got=%0d exp=0", dbl); end
        step();
    endtask

    task automatic test_back_to_back();
        int lat, pulses; logic [15:0] res;
        do_op(8'h80, 8'h80, 3'b001, 1'b0, lat, res, pulses);
        checks++; if (res !== 16'h0100) begin errors++; $display("FAIL b2b_first got=%h exp=0100", res); end
        do_op(8'h10, 8'h10, 3'b100, 1'b0, lat, res, pulses);
        checks++; if (res !== 16'h0100 || lat !== 3) begin
            errors++; $display("FAIL b2b_second got res=%h lat=%0d exp 0100/3", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_logic();
        test_rst_op();
        test_reset_abort();
        test_held_start();
        test_busy_ignore();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_core.md
# alu_core

Multi-cycle 8-bit ALU that responds to the operation handshake driven through the ALU bus-functional interface. It accepts two unsigned byte operands and a 3-bit opcode on a start request. It returns a 16-bit result with a one-cycle `done` pulse. Single-cycle logic ops and a 3-stage pipelined multiply share one result register. It is the DUT at the far end of the ALU stimulus path.

## Interface
- `MUL_LAT`, 3: multiply latency in cycles from acceptance to `done`; fixed, ≥2.
- `clk` in 1: single clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `A` in 8: operand A, unsigned.
- `B` in 8: operand B, unsigned.
- `op` in 3: opcode, `operation_t`.
- `start` in 1: request; held high by initiator until `done` seen.
- `done` out 1: one-cycle completion pulse.
- `result` out 16: registered result; valid when `done`=1, held until next `done`.

## Operation
- Opcodes: `no_op`=000, `add_op`=001, `and_op`=010, `xor_op`=011, `mul_op`=100, `rst_op`=111; 101/110 are treated as `no_op`.
- Acceptance happens only on a rising edge of `start`: `start`=1 this cycle, `start`=0 the previous sampled cycle, and FSM in IDLE. A, B and op are captured into internal registers at acceptance. Later input changes are ignored until completion.
- FSM states: IDLE → EXEC (all non-mul ops) → IDLE; IDLE → MUL (counts MUL_LAT-1 cycles) → IDLE. `done` is asserted on the transition out of EXEC/MUL.
- Results:
  - add: 9-bit sum zero-extended to 16.
  - and, xor: 8-bit result zero-extended.
  - mul: full 16-bit product.
  - no_op: `done` pulses, `result` unchanged.
  - rst_op: `done` pulses, `result` ← 0.
- `start` held high across and after `done` does not re-trigger. A new op requires `start` low for ≥1 sampled cycle.
- `start` rising while busy is ignored; it is not queued.

## Timing
- Reset: `done`=0, `result`=0x0000, FSM=IDLE, start-edge register=0 (so `start` already high when reset releases counts as a rising edge). Mul pipeline valid bits are cleared.
- Latency, from the accepting edge:
  - non-mul: `done` high in the following cycle (1).
  - mul: `done` high MUL_LAT cycles later (3).
- `result` updates on the same edge that raises `done`.
- `reset_n` low mid-operation aborts immediately. No `done` fires for the aborted op. The first op after release needs a fresh accept.
- Back-to-back: earliest re-accept is 2 cycles after `done` (start low, then high).
- `done` is never high for two consecutive cycles.

## Structure
- Shared package `def_pkg`: `operation_t` enum with the encodings above, and the `MUL_LAT` default constant.
- Sub-module `alu_mul_pipe`: 8×8 unsigned multiplier, MUL_LAT register stages, with a valid-in/valid-out bit that flushes on `reset_n`. The top-level FSM, capture registers, logic ops and result mux live in `alu_core`.

## Test plan
- add A=0xFF, B=0xFF, start rise at cycle 0 → `done`=1 at cycle 1, `result`=0x01FE; `result` still 0x01FE 5 cycles later.
- mul A=0xFF, B=0xFF → `done` only at cycle 3, `result`=0xFE01; A/B changed to 0x00 at cycle 1 → result unaffected.
- and 0xF0/0x3C → 0x0030; xor 0xF0/0x3C → 0x00CC; no_op after that → `done` pulses, `result` stays 0x00CC.
- rst_op after a nonzero result → `done` at cycle 1, `result`=0x0000; opcode 101 → behaves as no_op.
- mul started, `reset_n` pulsed low at cycle 2 → `done` never asserts; `done`=0 and `result`=0 during and after reset.
- `start` held high for 10 cycles with add 0x01+0x02 → exactly one `done` pulse, `result`=0x0003; start rise during an in-flight mul → ignored, single `done`.
